// File: rtl/serial_subtractor.sv
// Digit-serial two's-complement subtractor: diff = x - y, D bits per clock, LSB digit first.
// Borrow and signed overflow are registered alongside the result; valid/ready on both sides.
module serial_subtractor #(
   parameter int n = 4,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] diff,
   output logic         borrow,
   output logic         overflow
);

   localparam int NDIG = n / D;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_r, next_state_s;

   logic [n-1:0]  xs_r;
   logic [n-1:0]  ys_r;
   logic          carry_r;
   logic [CW-1:0] cnt_r;

   logic [D-1:0]  xd_s;
   logic [D-1:0]  yd_s;
   logic [D-1:0]  d_s;
   logic          c_s;
   logic          last_s;
   logic [n-1:0]  diff_next_s;

   // One digit of x + ~y + carry; on the final digit the operand MSBs sit at bit D-1.
   always_comb begin
      xd_s       = xs_r[D-1:0];
      yd_s       = ys_r[D-1:0];
      {c_s, d_s} = {1'b0, xd_s} + {1'b0, ~yd_s} + {{D{1'b0}}, carry_r};
      last_s     = (cnt_r == LAST);
   end

   generate
      if (D == n) begin : g_single_digit
         assign diff_next_s = d_s;
      end else begin : g_multi_digit
         assign diff_next_s = {d_s, diff[n-1:D]};
      end
   endgenerate

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Operand shifters, carry chain, digit counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xs_r     <= {n{1'b0}};
         ys_r     <= {n{1'b0}};
         carry_r  <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         diff     <= {n{1'b0}};
         borrow   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  xs_r    <= x;
                  ys_r    <= y;
                  carry_r <= 1'b1;
                  cnt_r   <= {CW{1'b0}};
               end
            end
            RUN: begin
               xs_r    <= xs_r >> D;
               ys_r    <= ys_r >> D;
               carry_r <= c_s;
               cnt_r   <= cnt_r + CW'(1'b1);
               diff    <= diff_next_s;
               if (last_s) begin
                  borrow   <= ~c_s;
                  // Signed overflow: operand signs differ and the result sign differs from x.
                  overflow <= (xd_s[D-1] & ~yd_s[D-1] & ~d_s[D-1]) |
                              (~xd_s[D-1] & yd_s[D-1] & d_s[D-1]);
               end
            end
            DONE: begin
               carry_r <= carry_r;
            end
            default: begin
               carry_r <= carry_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: n=4/D=1 and n=8/D=2 instances,
// table-driven vectors plus backpressure, mid-run reset and back-to-back sequences.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, borrow4, ovf4;
   logic [3:0] x4 = 4'd0, y4 = 4'd0, diff4;
   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, borrow8, ovf8;
   logic [7:0] x8 = 8'd0, y8 = 8'd0, diff8;

   serial_subtractor #(.n(4), .D(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .x(x4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready4),
      .diff(diff4), .borrow(borrow4), .overflow(ovf4));

   serial_subtractor #(.n(8), .D(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8),
      .diff(diff8), .borrow(borrow8), .overflow(ovf8));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic [3:0] diff;
      logic       borrow;
      logic       ovf;
   } vec4_t;

   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] diff;
      logic       borrow;
      logic       ovf;
   } vec8_t;

   vec4_t tbl4[8];
   vec8_t tbl8[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait4(input logic [3:0] ed, input logic eb, input logic eo, input string tag);
      int lat = 0;
      while (!out_valid4 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_diff"}, diff4, ed);
      chk({tag, "_borrow"}, borrow4, eb);
      chk({tag, "_overflow"}, ovf4, eo);
   endtask

   task automatic op4(input vec4_t v, input bit rel, input string tag);
      for (int k = 0; k < 20 && !in_ready4; k++) begin
         @(posedge clk); #1;
      end
      x4 = v.x; y4 = v.y; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      wait4(v.diff, v.borrow, v.ovf, tag);
      if (rel) begin
         out_ready4 = 1'b1;
         @(posedge clk); #1;
         out_ready4 = 1'b0;
         chk({tag, "_release"}, {out_valid4, in_ready4}, 2'b01);
      end
   endtask

   task automatic op8(input vec8_t v, input string tag);
      int lat = 0;
      for (int k = 0; k < 20 && !in_ready8; k++) begin
         @(posedge clk); #1;
      end
      x8 = v.x; y8 = v.y; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      while (!out_valid8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_diff"}, diff8, v.diff);
      chk({tag, "_borrow"}, borrow8, v.borrow);
      chk({tag, "_overflow"}, ovf8, v.ovf);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      chk({tag, "_release"}, {out_valid8, in_ready8}, 2'b01);
   endtask

   initial begin
      logic [3:0] a, b, ed;
      logic       eb, eo;
      int         sd, got, sent, cyc, last_t;
      logic [3:0] qx[$];
      logic [3:0] qy[$];

      tbl4[0] = '{4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0};
      tbl4[1] = '{4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0};
      tbl4[2] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1};
      tbl4[3] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
      tbl4[4] = '{4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0};
      tbl4[5] = '{4'b1001, 4'b0000, 4'b1001, 1'b0, 1'b0};
      tbl4[6] = '{4'b0000, 4'b1111, 4'b0001, 1'b1, 1'b0};
      tbl4[7] = '{4'b1010, 4'b0001, 4'b1001, 1'b0, 1'b0};

      tbl8[0] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
      tbl8[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
      tbl8[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      tbl8[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

      #2;
      chk("reset_in_ready", in_ready4, 1'b1);
      chk("reset_out_valid", out_valid4, 1'b0);
      chk("reset_results", {diff4, borrow4, ovf4}, 6'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         op4(tbl4[i], 1'b1, $sformatf("vec4_%0d", i));
      end
      for (int i = 0; i < 4; i++) begin
         op8(tbl8[i], $sformatf("vec8_%0d", i));
      end

      // Backpressure: result held, new operands ignored while DONE.
      op4(tbl4[1], 1'b0, "bp_op");
      x4 = 4'b1111; y4 = 4'b1111; in_valid4 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", in_ready4, 1'b0);
         chk("bp_hold", {out_valid4, diff4, borrow4, ovf4}, {1'b1, 4'b1110, 1'b1, 1'b0});
      end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      chk("bp_release", {out_valid4, in_ready4}, 2'b01);
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      wait4(4'b0000, 1'b0, 1'b0, "bp_next");
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;

      // Reset after two digit cycles.
      x4 = 4'b1010; y4 = 4'b0001; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("mid_running", in_ready4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", in_ready4, 1'b1);
      chk("mid_rst_out_valid", out_valid4, 1'b0);
      chk("mid_rst_results", {diff4, borrow4, ovf4}, 6'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      op4(tbl4[7], 1'b1, "after_rst");

      // Back-to-back with in_valid and out_ready held high.
      got = 0; sent = 0; cyc = 0; last_t = -1;
      in_valid4 = 1'b1; out_ready4 = 1'b1;
      while (got < 16 && cyc < 400) begin
         if (in_ready4 && sent < 16) begin
            x4 = 4'($urandom); y4 = 4'($urandom);
            qx.push_back(x4); qy.push_back(y4);
            sent++;
         end else if (in_ready4) begin
            in_valid4 = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (out_valid4) begin
            a = qx.pop_front(); b = qy.pop_front();
            ed = a - b;
            eb = (a < b);
            sd = int'($signed(a)) - int'($signed(b));
            eo = (sd > 7) || (sd < -8);
            chk($sformatf("b2b_%0d", got), {diff4, borrow4, ovf4}, {ed, eb, eo});
            if (last_t >= 0) chk("b2b_interval", cyc - last_t, 6);
            last_t = cyc;
            got++;
         end
      end
      in_valid4 = 1'b0;
      chk("b2b_count", got, 16);
      @(posedge clk); #1;
      chk("b2b_single_accept", out_valid4, 1'b0);
      out_ready4 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle n-bit two's-complement subtractor; the inverse operation of the team's combinational n-bit adder.
- Computes diff = x - y, processing D bits per clock, LSB digit first.
- Reports the unsigned borrow and the signed overflow, the counterparts of the adder's cout and overflow.
- Valid/ready handshake on both sides; sits in datapaths where area matters more than latency.

Parameters:
- n, 4, operand and result width in bits; must be a multiple of D, n >= 2.
- D, 1, digit width in bits processed per cycle; 1 <= D <= n.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands x, y present.
- in_ready  output  1  block can accept operands.
- x  input  n  minuend.
- y  input  n  subtrahend.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- diff  output  n  x - y modulo 2^n.
- borrow  output  1  1 when unsigned x < y.
- overflow  output  1  signed two's-complement overflow of x - y.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous assert, synchronous release to next edge):
  - state = IDLE.
  - in_ready = 1.
  - out_valid = 0.
  - diff = 0, borrow = 0, overflow = 0.
  - Internal operand registers, carry and digit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: latch x and y, set carry = 1 (computes x + ~y + 1), clear the digit counter, go to RUN.
  - in_valid = 0: stay in IDLE.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge processes one D-bit digit: {c, d} = xd + ~yd + carry.
  - The digit d is shifted into diff from the MSB side, so after n/D digits the LSB digit sits at diff[D-1:0].
  - carry <= c; counter increments.
  - in_valid is ignored during RUN.
- RUN to DONE:
  - On the edge that processes digit n/D-1.
  - On that same edge: borrow <= ~c (final carry).
  - On that same edge: overflow <= (x[n-1] & ~y[n-1] & ~diff_msb) | (~x[n-1] & y[n-1] & diff_msb), where diff_msb is bit n-1 of the completed result.
- Latency:
  - out_valid rises exactly n/D cycles after the accepting edge.
  - Throughput is one operation per n/D + 2 cycles when out_ready = 1.
- DONE:
  - out_valid = 1; diff, borrow and overflow are held stable.
  - Stay in DONE while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE, out_valid = 0.
  - diff, borrow and overflow retain their values until the next operation starts shifting.
- Output validity: diff is a live shift register during RUN. diff, borrow and overflow are meaningful only while out_valid = 1.
- Width rules:
  - diff wraps modulo 2^n.
  - borrow is the complement of the adder-style carry-out of x + ~y + 1.
  - x = y gives diff = 0, borrow = 0, overflow = 0.
  - y = 0 gives borrow = 0.
- Reset mid-operation (RUN or DONE): immediate return to reset values; the partial result is discarded.
- No simultaneous input and output handshake: in_ready = 0 outside IDLE.

Test Plan:
- n=4, D=1: x=0101, y=0011 -> out_valid exactly 4 cycles after accept; diff=0010, borrow=0, overflow=0.
- n=4, D=1: x=0011, y=0101 -> diff=1110, borrow=1, overflow=0. Then x=0111, y=1000 -> diff=1111, borrow=1, overflow=1. Then x=1000, y=0001 -> diff=0111, borrow=0, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands -> in_ready=0 throughout; diff/borrow/overflow unchanged; new operands not latched. Then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
- Reset mid-RUN: drop rst_n after 2 digit cycles of x=1010, y=0001 -> outputs 0 and in_ready=1 without waiting for an edge. After release, x=1010, y=0001 -> diff=1001, borrow=0, overflow=0.
- n=8, D=2: x=0x10, y=0x01 -> out_valid 4 cycles after accept; diff=0x0F, borrow=0. x=0x00, y=0x01 -> diff=0xFF, borrow=1, overflow=0.
- Back-to-back: in_valid and out_ready held at 1, 16 random operand pairs -> every result matches the reference model x - y, borrow = (x < y), and signed overflow; each result is accepted exactly once.
